// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sequencer and its accumulator bank.
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } adc_seq_state_t;

    // Index width that stays legal when only a single channel is scanned.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_accum_bank.sv
// Per-channel sample accumulators plus the latched bank of averaged results.
module adc_accum_bank
    import adc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int AVG_LOG2 = 2,
    parameter int IDX_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  add_en_i,
    input  logic [IDX_W-1:0]      add_idx_i,
    input  logic [ADC_DATA_W-1:0] add_data_i,
    input  logic                  latch_en_i,
    input  logic [IDX_W-1:0]      latch_idx_i,
    output logic [ADC_DATA_W-1:0] avg_o,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [ADC_DATA_W-1:0] rd_data_o
);

    localparam int ACC_W = ADC_DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]      acc_q  [NUM_CH];
    logic [ADC_DATA_W-1:0] bank_q [NUM_CH];
    logic [ACC_W-1:0]      shifted_s;

    // Average of the channel selected for latching (truncating divide).
    always_comb begin
        shifted_s = '0;
        avg_o     = '0;
        if (int'(latch_idx_i) < NUM_CH) begin
            shifted_s = acc_q[latch_idx_i] >> AVG_LOG2;
            avg_o     = shifted_s[ADC_DATA_W-1:0];
        end else begin
            avg_o     = '0;
        end
    end

    // Accumulate responses; clear has priority, latch writes the result bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                bank_q[i] <= '0;
            end
        end else begin
            if (clr_i) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_q[i] <= '0;
                end
            end else if (add_en_i) begin
                acc_q[add_idx_i] <= acc_q[add_idx_i] + ACC_W'(add_data_i);
            end
            if (latch_en_i) begin
                bank_q[latch_idx_i] <= avg_o;
            end
        end
    end

    // Combinational read port of the result bank.
    always_comb begin
        rd_data_o = '0;
        if (int'(rd_idx_i) < NUM_CH) begin
            rd_data_o = bank_q[rd_idx_i];
        end else begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// Scans a channel range on the ADC command stream, averages the responses
// per channel and emits the averages as a stream and into a result bank.
module adc_sequencer
    import adc_pkg::*;
#(
    parameter int FIRST_CH = 1,
    parameter int NUM_CH   = 4,
    parameter int AVG_LOG2 = 2,
    parameter int MAX_OUT  = 2,
    localparam int IDX_W   = idx_width(NUM_CH),
    localparam int PASS_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    output logic                  busy,
    output logic                  command_valid,
    output logic [ADC_CH_W-1:0]   command_channel,
    output logic                  command_startofpacket,
    output logic                  command_endofpacket,
    input  logic                  command_ready,
    input  logic                  response_valid,
    input  logic [ADC_CH_W-1:0]   response_channel,
    input  logic [ADC_DATA_W-1:0] response_data,
    input  logic                  response_startofpacket,
    input  logic                  response_endofpacket,
    input  logic [0:0]            response_empty,
    output logic                  sample_valid,
    output logic [ADC_CH_W-1:0]   sample_channel,
    output logic [ADC_DATA_W-1:0] sample_data,
    output logic                  scan_done,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [ADC_DATA_W-1:0] rd_data,
    output logic                  ch_err
);

    adc_seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, e_q, e_d;
    logic [PASS_W-1:0]     pass_q, pass_d;
    logic [1:0]            out_cnt_q, out_cnt_d;
    logic                  ch_err_q, ch_err_d, busy_q, busy_d;
    logic                  cmd_valid_s, accept_s, resp_in_range_s, resp_count_s;
    logic                  add_en_s, clr_s, latch_en_s, last_idx_s, last_pass_s, last_e_s;
    logic [ADC_CH_W-1:0]   resp_r_s;
    logic [ADC_DATA_W-1:0] avg_s;
    logic                  unused_s;

    assign unused_s        = ^{response_startofpacket, response_endofpacket, response_empty};
    assign cmd_valid_s     = (state_q == ISSUE) && (out_cnt_q < 2'(MAX_OUT));
    assign accept_s        = cmd_valid_s && command_ready;
    assign resp_r_s        = response_channel - ADC_CH_W'(FIRST_CH);
    assign resp_in_range_s = resp_r_s < ADC_CH_W'(NUM_CH);
    assign resp_count_s    = response_valid && (out_cnt_q != 2'd0);
    assign add_en_s        = resp_count_s && resp_in_range_s;
    assign last_idx_s      = idx_q == IDX_W'(NUM_CH - 1);
    assign last_pass_s     = pass_q == PASS_W'((1 << AVG_LOG2) - 1);
    assign last_e_s        = e_q == IDX_W'(NUM_CH - 1);

    adc_accum_bank #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (clr_s),
        .add_en_i    (add_en_s),
        .add_idx_i   (resp_r_s[IDX_W-1:0]),
        .add_data_i  (response_data),
        .latch_en_i  (latch_en_s),
        .latch_idx_i (e_q),
        .avg_o       (avg_s),
        .rd_idx_i    (rd_idx),
        .rd_data_o   (rd_data)
    );

    // Outstanding-command count and sticky channel error.
    always_comb begin
        out_cnt_d = out_cnt_q;
        ch_err_d  = ch_err_q;
        case ({accept_s, resp_count_s})
            2'b10:   out_cnt_d = out_cnt_q + 2'd1;
            2'b01:   out_cnt_d = out_cnt_q - 2'd1;
            default: out_cnt_d = out_cnt_q;
        endcase
        if (response_valid && ((resp_count_s && !resp_in_range_s) ||
                               (!resp_count_s && (state_q != IDLE)))) begin
            ch_err_d = 1'b1;
        end else begin
            ch_err_d = ch_err_q;
        end
    end

    // Scan FSM: next state, scan counters and accumulator control.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        e_d        = e_q;
        clr_s      = 1'b0;
        latch_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || enable) begin
                    state_d = ISSUE;
                    clr_s   = 1'b1;
                    idx_d   = '0;
                    pass_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (accept_s && last_idx_s) begin
                    idx_d = '0;
                    if (last_pass_s) begin
                        state_d = DRAIN;
                        pass_d  = '0;
                    end else begin
                        pass_d  = pass_q + PASS_W'(1);
                    end
                end else if (accept_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            DRAIN: begin
                if ((out_cnt_q == 2'd0) && !response_valid) begin
                    state_d = EMIT;
                    e_d     = '0;
                end else begin
                    state_d = DRAIN;
                end
            end
            EMIT: begin
                latch_en_s = 1'b1;
                if (last_e_s) begin
                    e_d = '0;
                    if (enable) begin
                        state_d = ISSUE;
                        clr_s   = 1'b1;
                        idx_d   = '0;
                        pass_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    e_d = e_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pass_q    <= '0;
            e_q       <= '0;
            out_cnt_q <= 2'd0;
            ch_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            e_q       <= e_d;
            out_cnt_q <= out_cnt_d;
            ch_err_q  <= ch_err_d;
            busy_q    <= busy_d;
        end
    end

    // Stream outputs decoded from registered state only.
    always_comb begin
        command_valid         = 1'b0;
        command_channel       = '0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;
        sample_valid          = 1'b0;
        sample_channel        = '0;
        sample_data           = '0;
        scan_done             = 1'b0;
        case (state_q)
            ISSUE: begin
                command_valid         = cmd_valid_s;
                command_channel       = ADC_CH_W'(FIRST_CH) + ADC_CH_W'(idx_q);
                command_startofpacket = idx_q == '0;
                command_endofpacket   = last_idx_s;
            end
            EMIT: begin
                sample_valid   = 1'b1;
                sample_channel = ADC_CH_W'(FIRST_CH) + ADC_CH_W'(e_q);
                sample_data    = avg_s;
                scan_done      = last_e_s;
            end
            default: begin
                command_valid = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign ch_err = ch_err_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed scan scenarios with randomized data and backpressure, checked
// against a per-channel sum model fed by the bench's own responder.
module tb_adc_sequencer;

    localparam int FIRST_CH = 1;
    localparam int NUM_CH   = 2;
    localparam int AVG_LOG2 = 2;
    localparam int MAX_OUT  = 2;
    localparam int NSAMP    = 1 << AVG_LOG2;
    localparam int LAT      = 3;

    logic        clk = 1'b0;
    logic        reset, enable, start, command_ready;
    logic        busy, command_valid, command_startofpacket, command_endofpacket;
    logic [4:0]  command_channel, response_channel, sample_channel;
    logic        response_valid, response_startofpacket, response_endofpacket;
    logic [11:0] response_data, sample_data, rd_data;
    logic [0:0]  response_empty, rd_idx;
    logic        sample_valid, scan_done, ch_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_sequencer #(
        .FIRST_CH (FIRST_CH),
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .start                  (start),
        .busy                   (busy),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .command_ready          (command_ready),
        .response_valid         (response_valid),
        .response_channel       (response_channel),
        .response_data          (response_data),
        .response_startofpacket (response_startofpacket),
        .response_endofpacket   (response_endofpacket),
        .response_empty         (response_empty),
        .sample_valid           (sample_valid),
        .sample_channel         (sample_channel),
        .sample_data            (sample_data),
        .scan_done              (scan_done),
        .rd_idx                 (rd_idx),
        .rd_data                (rd_data),
        .ch_err                 (ch_err)
    );

    typedef struct {
        int         due;
        logic [4:0] ch;
    } pend_t;

    pend_t pend_q[$];
    int    cyc = 0;
    int    sums[NUM_CH];
    int    resp_per_ch[NUM_CH];
    int    cmd_in_scan = 0, sample_seq = 0, done_cnt = 0, max_pend = 0;
    int    coincide = 0, stray_in_idle = 0;
    bit    bp_mode = 1'b0, rand_data = 1'b0, bad_next = 1'b0, stray_req = 1'b0;
    bit    stalled = 1'b0, prev_done = 1'b0, prev_en = 1'b0;
    logic [6:0] st_payload;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_CH; i++) begin
            sums[i]        = 0;
            resp_per_ch[i] = 0;
        end
        cmd_in_scan = 0;
        sample_seq  = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) tick(1);
        check("scan_done_count", done_cnt, target);
    endtask

    task automatic check_bank(input int exp0, input int exp1);
        rd_idx = 1'b0;
        #1;
        check("rd_data0", rd_data, exp0);
        rd_idx = 1'b1;
        #1;
        check("rd_data1", rd_data, exp1);
    endtask

    // Responder, command/sample monitor and model, all on the falling edge.
    initial begin
        pend_t p;
        int    ix;
        bit    accept;
        command_ready = 1'b1;
        response_valid = 1'b0;
        response_channel = 5'd0;
        response_data = 12'd0;
        response_startofpacket = 1'b0;
        response_endofpacket = 1'b0;
        response_empty = 1'b0;
        clear_model();
        forever begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("cmd_hold_valid", command_valid, 1);
                check("cmd_hold_payload",
                      {command_channel, command_startofpacket, command_endofpacket}, st_payload);
            end
            if (prev_done && prev_en)  check("issue_resume", command_valid, 1);
            if (prev_done && !prev_en) check("idle_after_scan", busy, 0);
            prev_done = scan_done;
            prev_en   = enable;
            if (sample_valid) begin
                check("sample_channel", sample_channel, FIRST_CH + sample_seq);
                check("sample_data", sample_data, sums[sample_seq] >> AVG_LOG2);
                check("scan_done_flag", scan_done, sample_seq == NUM_CH - 1);
                if (sample_seq == NUM_CH - 1) begin
                    check("cmds_per_scan", cmd_in_scan, NUM_CH * NSAMP);
                    done_cnt++;
                    clear_model();
                end else begin
                    sample_seq++;
                end
            end
            command_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            accept = command_valid && command_ready && !reset;
            response_valid   = 1'b0;
            response_channel = 5'd0;
            response_data    = 12'd0;
            if (stray_req) begin
                stray_req        = 1'b0;
                response_valid   = 1'b1;
                response_channel = 5'(FIRST_CH);
                response_data    = 12'd777;
                if (!busy) stray_in_idle++;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p  = pend_q.pop_front();
                ix = int'(p.ch) - FIRST_CH;
                response_data = rand_data ? 12'($urandom_range(0, 4095))
                                          : 12'(100 * int'(p.ch) + resp_per_ch[ix]);
                resp_per_ch[ix]++;
                response_valid = 1'b1;
                if (bad_next) begin
                    bad_next         = 1'b0;
                    response_channel = 5'd9;
                end else begin
                    response_channel = p.ch;
                    sums[ix] += int'(response_data);
                end
                if (!busy) stray_in_idle++;
                if (accept) coincide++;
            end
            if (accept) begin
                check("cmd_channel", command_channel, FIRST_CH + cmd_in_scan % NUM_CH);
                check("cmd_sop", command_startofpacket, (cmd_in_scan % NUM_CH) == 0);
                check("cmd_eop", command_endofpacket, (cmd_in_scan % NUM_CH) == NUM_CH - 1);
                cmd_in_scan++;
                pend_q.push_back('{due: cyc + LAT, ch: command_channel});
            end
            if (pend_q.size() > max_pend) max_pend = pend_q.size();
            stalled    = command_valid && !command_ready && !reset;
            st_payload = {command_channel, command_startofpacket, command_endofpacket};
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        start  = 1'b0;
        rd_idx = 1'b0;
        tick(3);
        check("rst_cmd_valid", command_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_ch_err", ch_err, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        tick(2);

        // Single scan with the channel/pass pattern responder.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("first_cmd_valid", command_valid, 1);
        check("busy_in_scan", busy, 1);
        wait_done(1, 300);
        check_bank(101, 201);
        tick(2);
        check("busy_idle", busy, 0);

        // Same scan under random command backpressure.
        bp_mode = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(2, 600);
        check("max_outstanding_ok", max_pend <= MAX_OUT, 1);
        check_bank(101, 201);

        // Continuous scanning with random data; enable dropped mid third scan.
        rand_data = 1'b1;
        enable = 1'b1;
        wait_done(4, 1200);
        tick(3);
        check("scan3_busy", busy, 1);
        enable = 1'b0;
        wait_done(5, 600);
        tick(5);
        check("idle_after_enable_drop", busy, 0);
        check("no_extra_scan", done_cnt, 5);

        // One response arrives on an out-of-range channel.
        rand_data = 1'b0;
        bp_mode = 1'b0;
        bad_next = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(6, 300);
        check("bad_ch_err", ch_err, 1);
        check_bank(76, 201);

        // Reset in ISSUE, then in-flight and stray responses while idle.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_cmd_valid", command_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ch_err", ch_err, 0);
        check("mid_rst_rd_data", rd_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 20 && pend_q.size() > 0; i++) tick(1);
        check("inflight_flushed", pend_q.size(), 0);
        stray_req = 1'b1;
        tick(3);
        check("stray_seen_idle", stray_in_idle > 0, 1);
        check("stray_no_err", ch_err, 0);
        check("stray_busy", busy, 0);
        clear_model();
        coincide = 0;

        // Fresh scan after reset; accepts and responses coincide.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(7, 300);
        check_bank(101, 201);
        check("coincident_seen", coincide > 0, 1);
        check("final_ch_err", ch_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
